// File: rtl/ctrl_evt_dispatch.sv
// Turns rising edges of a synchronized control level into queued events and
// dispatches them one at a time over a req/ack handshake with a bounded wait.
module ctrl_evt_dispatch #(
  parameter int CNT_W  = 4,
  parameter int TO_W   = 8,
  parameter int TO_CYC = 200
) (
  input  logic             clk_dest,
  input  logic             rst_dest_n,
  input  logic             ctrl_sync_i,
  input  logic             clr_i,
  input  logic             evt_ack_i,
  output logic             evt_req_o,
  output logic [CNT_W-1:0] pend_cnt_o,
  output logic             ovf_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit               TO_EN   = (TO_CYC != 0);
  localparam logic [TO_W-1:0]  TO_LAST = TO_EN ? TO_W'(TO_CYC - 1) : '0;

  state_t          state;
  logic            ctrl_d;
  logic [TO_W-1:0] timer;
  logic            rise, ack, to_hit, done;

  assign rise   = ctrl_sync_i & ~ctrl_d;
  assign ack    = (state == REQ) & evt_ack_i;
  // Ack on the expiry edge wins, so the drop only fires without an ack.
  assign to_hit = TO_EN & (state == REQ) & ~evt_ack_i & (timer == TO_LAST);
  assign done   = ack | to_hit;

  always_ff @(posedge clk_dest or negedge rst_dest_n) begin
    if (!rst_dest_n) begin
      state      <= IDLE;
      ctrl_d     <= 1'b0;
      timer      <= '0;
      evt_req_o  <= 1'b0;
      pend_cnt_o <= '0;
      ovf_o      <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      ctrl_d    <= ctrl_sync_i;
      timeout_o <= 1'b0;
      if (clr_i) begin
        state      <= IDLE;
        timer      <= '0;
        evt_req_o  <= 1'b0;
        pend_cnt_o <= '0;
        ovf_o      <= 1'b0;
      end else begin
        // A rise and a completed dispatch on the same edge cancel out.
        if (rise && !done) begin
          if (pend_cnt_o == CNT_MAX) ovf_o <= 1'b1;
          else                       pend_cnt_o <= pend_cnt_o + 1'b1;
        end else if (done && !rise) begin
          pend_cnt_o <= pend_cnt_o - 1'b1;
        end

        case (state)
          IDLE: begin
            timer <= '0;
            if (pend_cnt_o != '0) begin
              state     <= REQ;
              evt_req_o <= 1'b1;
            end
          end
          REQ: begin
            timer <= timer + 1'b1;
            if (done) begin
              state     <= GAP;
              evt_req_o <= 1'b0;
              timeout_o <= to_hit;
            end
          end
          GAP: begin
            timer <= '0;
            if (pend_cnt_o != '0) begin
              state     <= REQ;
              evt_req_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          default: begin
            state     <= IDLE;
            evt_req_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctrl_evt_dispatch.sv
// Directed bench: dut_a uses an 8-cycle timeout, dut_b has the timeout disabled
// for the overflow scenario. Both share stimulus.
module tb_ctrl_evt_dispatch;

  logic clk_dest = 1'b0;
  logic rst_dest_n = 1'b0;
  logic ctrl_sync_i = 1'b0;
  logic clr_i = 1'b0;
  logic evt_ack_i = 1'b0;

  logic       req_a, ovf_a, to_a;
  logic [3:0] cnt_a;
  logic       req_b, ovf_b, to_b;
  logic [3:0] cnt_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_dest = ~clk_dest;

  ctrl_evt_dispatch #(.CNT_W(4), .TO_W(8), .TO_CYC(8)) dut_a (
    .clk_dest(clk_dest), .rst_dest_n(rst_dest_n), .ctrl_sync_i(ctrl_sync_i),
    .clr_i(clr_i), .evt_ack_i(evt_ack_i), .evt_req_o(req_a),
    .pend_cnt_o(cnt_a), .ovf_o(ovf_a), .timeout_o(to_a));

  ctrl_evt_dispatch #(.CNT_W(4), .TO_W(8), .TO_CYC(0)) dut_b (
    .clk_dest(clk_dest), .rst_dest_n(rst_dest_n), .ctrl_sync_i(ctrl_sync_i),
    .clr_i(clr_i), .evt_ack_i(evt_ack_i), .evt_req_o(req_b),
    .pend_cnt_o(cnt_b), .ovf_o(ovf_b), .timeout_o(to_b));

  task automatic tick();
    @(posedge clk_dest);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic r, input logic [3:0] c,
                       input logic o, input logic t);
    chk({tag, ".req"}, 32'(req_a), 32'(r));
    chk({tag, ".cnt"}, 32'(cnt_a), 32'(c));
    chk({tag, ".ovf"}, 32'(ovf_a), 32'(o));
    chk({tag, ".to"},  32'(to_a),  32'(t));
  endtask

  task automatic do_reset();
    ctrl_sync_i = 1'b0; clr_i = 1'b0; evt_ack_i = 1'b0;
    rst_dest_n = 1'b0;
    tick(); tick();
    rst_dest_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk_a("rst_a", 1'b0, 4'd0, 1'b0, 1'b0);
    chk("rst_b.req", 32'(req_b), 32'd0);
    chk("rst_b.cnt", 32'(cnt_b), 32'd0);
    do_reset();

    // Single event, ack one cycle after req rises
    ctrl_sync_i = 1'b1;
    tick(); chk_a("single_k",  1'b0, 4'd1, 1'b0, 1'b0);
    tick(); chk_a("single_k1", 1'b1, 4'd1, 1'b0, 1'b0);
    tick(); chk_a("single_k2", 1'b1, 4'd1, 1'b0, 1'b0);
    evt_ack_i = 1'b1;
    tick(); chk_a("single_ack", 1'b0, 4'd0, 1'b0, 1'b0);
    evt_ack_i = 1'b0; ctrl_sync_i = 1'b0;
    tick(); chk_a("single_gap", 1'b0, 4'd0, 1'b0, 1'b0);
    tick(); chk_a("single_idle", 1'b0, 4'd0, 1'b0, 1'b0);

    // Burst of three rises with 2-cycle low gaps, then continuous ack
    do_reset();
    ctrl_sync_i = 1'b1; tick(); chk_a("burst_e0", 1'b0, 4'd1, 1'b0, 1'b0);
    ctrl_sync_i = 1'b0; tick(); tick();
    ctrl_sync_i = 1'b1; tick(); chk_a("burst_e3", 1'b1, 4'd2, 1'b0, 1'b0);
    ctrl_sync_i = 1'b0; tick(); tick();
    ctrl_sync_i = 1'b1; tick(); chk_a("burst_e6", 1'b1, 4'd3, 1'b0, 1'b0);
    chk("burst_b.cnt", 32'(cnt_b), 32'd3);
    ctrl_sync_i = 1'b0; evt_ack_i = 1'b1;
    tick(); chk_a("burst_e7",  1'b0, 4'd2, 1'b0, 1'b0);
    tick(); chk_a("burst_e8",  1'b1, 4'd2, 1'b0, 1'b0);
    tick(); chk_a("burst_e9",  1'b0, 4'd1, 1'b0, 1'b0);
    tick(); chk_a("burst_e10", 1'b1, 4'd1, 1'b0, 1'b0);
    tick(); chk_a("burst_e11", 1'b0, 4'd0, 1'b0, 1'b0);
    evt_ack_i = 1'b0;
    tick(); chk_a("burst_e12", 1'b0, 4'd0, 1'b0, 1'b0);

    // Overflow on the no-timeout instance
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      ctrl_sync_i = 1'b1; tick();
      if (i == 15) begin
        chk("ovf_15.cnt", 32'(cnt_b), 32'd15);
        chk("ovf_15.ovf", 32'(ovf_b), 32'd0);
      end
      ctrl_sync_i = 1'b0; tick();
    end
    chk("ovf_16.cnt", 32'(cnt_b), 32'd15);
    chk("ovf_16.ovf", 32'(ovf_b), 32'd1);
    chk("ovf_16.req", 32'(req_b), 32'd1);
    evt_ack_i = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    evt_ack_i = 1'b0;
    chk("ovf_drain.cnt", 32'(cnt_b), 32'd0);
    chk("ovf_drain.req", 32'(req_b), 32'd0);
    chk("ovf_drain.ovf", 32'(ovf_b), 32'd1);
    chk("ovf_drain.to",  32'(to_b),  32'd0);
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    chk("ovf_clr.ovf", 32'(ovf_b), 32'd0);
    chk("ovf_clr.cnt", 32'(cnt_b), 32'd0);

    // Timeout: req high exactly 8 cycles, then one timeout pulse
    do_reset();
    ctrl_sync_i = 1'b1; tick(); ctrl_sync_i = 1'b0;
    tick(); chk_a("to_req1", 1'b1, 4'd1, 1'b0, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("to_hold.req", 32'(req_a), 32'd1);
      chk("to_hold.to",  32'(to_a),  32'd0);
    end
    tick(); chk_a("to_fire", 1'b0, 4'd0, 1'b0, 1'b1);
    tick(); chk_a("to_gap",  1'b0, 4'd0, 1'b0, 1'b0);
    tick(); chk_a("to_idle", 1'b0, 4'd0, 1'b0, 1'b0);

    // Ack in the 8th high cycle: ack wins over expiry
    ctrl_sync_i = 1'b1; tick(); ctrl_sync_i = 1'b0;
    tick(); chk_a("toack_req1", 1'b1, 4'd1, 1'b0, 1'b0);
    for (int i = 2; i <= 8; i++) tick();
    chk_a("toack_req8", 1'b1, 4'd1, 1'b0, 1'b0);
    evt_ack_i = 1'b1;
    tick(); chk_a("toack_edge", 1'b0, 4'd0, 1'b0, 1'b0);
    evt_ack_i = 1'b0;
    tick(); chk_a("toack_after", 1'b0, 4'd0, 1'b0, 1'b0);

    // Rise on the same edge as ack with count=2
    do_reset();
    ctrl_sync_i = 1'b1; tick();
    ctrl_sync_i = 1'b0; tick();
    ctrl_sync_i = 1'b1; tick(); chk_a("sim_cnt2", 1'b1, 4'd2, 1'b0, 1'b0);
    ctrl_sync_i = 1'b0; tick();
    ctrl_sync_i = 1'b1; evt_ack_i = 1'b1;
    tick(); chk_a("sim_rise_ack", 1'b0, 4'd2, 1'b0, 1'b0);
    evt_ack_i = 1'b0;

    // Build to 5, then clr on the same edge as a rise
    ctrl_sync_i = 1'b0; tick();
    ctrl_sync_i = 1'b1; tick();
    ctrl_sync_i = 1'b0; tick();
    ctrl_sync_i = 1'b1; tick();
    ctrl_sync_i = 1'b0; tick();
    ctrl_sync_i = 1'b1; tick(); chk_a("clr_cnt5", 1'b1, 4'd5, 1'b0, 1'b0);
    ctrl_sync_i = 1'b0; tick();
    ctrl_sync_i = 1'b1; clr_i = 1'b1;
    tick(); chk_a("clr_rise", 1'b0, 4'd0, 1'b0, 1'b0);
    clr_i = 1'b0;
    tick(); chk_a("clr_held1", 1'b0, 4'd0, 1'b0, 1'b0);
    tick(); chk_a("clr_held2", 1'b0, 4'd0, 1'b0, 1'b0);
    ctrl_sync_i = 1'b0; tick();

    // Reset mid-REQ with count=3
    ctrl_sync_i = 1'b1; tick();
    ctrl_sync_i = 1'b0; tick();
    ctrl_sync_i = 1'b1; tick();
    ctrl_sync_i = 1'b0; tick();
    ctrl_sync_i = 1'b1; tick(); chk_a("mid_cnt3", 1'b1, 4'd3, 1'b0, 1'b0);
    #2 rst_dest_n = 1'b0;
    #1 chk_a("mid_rst_now", 1'b0, 4'd0, 1'b0, 1'b0);
    tick(); tick();
    rst_dest_n = 1'b1;
    tick(); chk_a("mid_rel_k",  1'b0, 4'd1, 1'b0, 1'b0);
    tick(); chk_a("mid_rel_k1", 1'b1, 4'd1, 1'b0, 1'b0);
    tick(); chk_a("mid_rel_k2", 1'b1, 4'd1, 1'b0, 1'b0);
    evt_ack_i = 1'b1;
    tick(); chk_a("mid_ack", 1'b0, 4'd0, 1'b0, 1'b0);
    evt_ack_i = 1'b0;
    tick(); tick(); chk_a("mid_one_evt", 1'b0, 4'd0, 1'b0, 1'b0);
    ctrl_sync_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
